// File: rtl/apb_timer_array_if.sv
// apb_timer_array_if: APB bus bundle between a master and the apb_timer_array slave
// Signals: PADDR/PWDATA/PWRITE/PSEL/PENABLE driven by master; PRDATA/PREADY/PSLVERR by slave.
interface apb_timer_array_if #(parameter int APB_ADDR_WIDTH = 12);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;
    modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PRDATA, PREADY, PSLVERR);
    modport slave  (input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_timer_array.sv
// apb_timer_array: APB slave with TIMER_CNT prescaled up-counters, compare reload, one-shot, W1C flags, level IRQs
// Ports: HCLK clock; HRESETn async active-low reset; apb APB slave bus (PADDR[7:4] channel, [3:2] register);
//        irq_o[2k] overflow IRQ, irq_o[2k+1] compare IRQ of channel k.
// Optional: define APB_TIMER_CASCADE_EN to let channel k>=1 tick on channel k-1 overflow/compare events (CTRL[4]).
module apb_timer_array #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMER_CNT      = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    apb_timer_array_if.slave       apb,
    output logic [2*TIMER_CNT-1:0] irq_o
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [4:0] LP_NCH = 5'(TIMER_CNT);
    logic [3:0]                    w_ch;
    logic [1:0]                    w_reg;
    logic                          w_ok;
    logic                          w_wr;
    logic                          w_unused;
    logic [31:0]                   w_rdata;
    logic [TIMER_CNT-1:0][3:0][31:0] w_rdv;
    assign w_ch         = apb.PADDR[7:4];
    assign w_reg        = apb.PADDR[3:2];
    assign w_ok         = {1'b0, w_ch} < LP_NCH;
    assign w_wr         = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign apb.PREADY   = 1'b1;
    assign apb.PSLVERR  = apb.PSEL & apb.PENABLE & ~w_ok;
    assign apb.PRDATA   = apb.PSEL ? w_rdata : '0;
    assign w_unused     = ^{apb.PADDR[1:0], apb.PADDR[APB_ADDR_WIDTH-1:8], apb.PWDATA};
    // Out-of-range channels match no index, so they read 0 and take no writes.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < TIMER_CNT; i++) w_rdata = (w_ch == 4'(i)) ? w_rdv[i][w_reg] : w_rdata;
    end
`ifdef APB_TIMER_CASCADE_EN
    logic [TIMER_CNT-1:0] w_evt;
    logic [TIMER_CNT-1:0] r_evt;
    // Events are registered so a chained channel ticks the cycle after its source event.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_evt <= '0;
        else          r_evt <= w_evt;
    end
`endif
    for (genvar k = 0; k < TIMER_CNT; k++) begin : g_ch
        state_t                r_state;
        logic                  r_os, r_oie, r_cie, r_ovf, r_cmpf, r_irq_ovf, r_irq_cmp;
        logic [7:0]            r_presc, r_pcnt;
        logic [CNT_WIDTH-1:0]  r_count, r_cmp;
        logic                  w_en, w_sel, w_pm, w_tick, w_match, w_wrap, w_cas;
        logic                  w_wr_ctrl, w_wr_cnt, w_wr_cmp, w_wr_st, w_set_cmp, w_set_ovf;
        assign w_en      = r_state == RUN;
        assign w_sel     = w_wr & (w_ch == 4'(k));
        assign w_wr_ctrl = w_sel & (w_reg == 2'd0);
        assign w_wr_cnt  = w_sel & (w_reg == 2'd1);
        assign w_wr_cmp  = w_sel & (w_reg == 2'd2);
        assign w_wr_st   = w_sel & (w_reg == 2'd3);
        assign w_pm      = r_pcnt == r_presc;
`ifdef APB_TIMER_CASCADE_EN
        logic r_cas, w_cin;
        if (k == 0) begin : g_first
            assign w_cin = 1'b0;
        end else begin : g_next
            assign w_cin = r_evt[k-1];
        end
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn)       r_cas <= 1'b0;
            else if (w_wr_ctrl) r_cas <= (k > 0) & apb.PWDATA[4];
        end
        assign w_cas    = r_cas;
        assign w_tick   = w_en & (w_cas ? w_cin : w_pm);
        assign w_evt[k] = w_set_cmp | w_set_ovf;
`else
        assign w_cas  = 1'b0;
        assign w_tick = w_en & w_pm;
`endif
        assign w_match   = w_tick & (r_count == r_cmp);
        assign w_wrap    = w_tick & ~w_match & (r_count == '1);
        // A COUNT write in the tick cycle swallows that tick and any flag it would raise.
        assign w_set_cmp = w_match & ~w_wr_cnt;
        assign w_set_ovf = w_wrap & ~w_wr_cnt;
        assign w_rdv[k][0] = {16'd0, r_presc, 3'd0, w_cas, r_cie, r_oie, r_os, w_en};
        assign w_rdv[k][1] = 32'(r_count);
        assign w_rdv[k][2] = 32'(r_cmp);
        assign w_rdv[k][3] = {30'd0, r_cmpf, r_ovf};
        assign irq_o[2*k]   = r_irq_ovf;
        assign irq_o[2*k+1] = r_irq_cmp;
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                r_state   <= IDLE;
                r_os      <= 1'b0;
                r_oie     <= 1'b0;
                r_cie     <= 1'b0;
                r_presc   <= '0;
                r_pcnt    <= '0;
                r_count   <= '0;
                r_cmp     <= '0;
                r_ovf     <= 1'b0;
                r_cmpf    <= 1'b0;
                r_irq_ovf <= 1'b0;
                r_irq_cmp <= 1'b0;
            end else begin
                r_pcnt <= (~w_en | w_wr_ctrl | w_pm) ? 8'd0 : r_pcnt + 8'd1;
                if (w_wr_cnt)    r_count <= apb.PWDATA[CNT_WIDTH-1:0];
                else if (w_tick) r_count <= (w_match | w_wrap) ? '0 : r_count + CNT_WIDTH'(1);
                if (w_wr_cmp) r_cmp <= apb.PWDATA[CNT_WIDTH-1:0];
                // The CTRL write takes precedence over a one-shot stop in the same cycle.
                if (w_wr_ctrl) begin
                    r_state <= apb.PWDATA[0] ? RUN : IDLE;
                    r_os    <= apb.PWDATA[1];
                    r_oie   <= apb.PWDATA[2];
                    r_cie   <= apb.PWDATA[3];
                    r_presc <= apb.PWDATA[15:8];
                end else if (w_set_cmp & r_os) begin
                    r_state <= IDLE;
                end
                r_ovf     <= w_set_ovf | (r_ovf & ~(w_wr_st & apb.PWDATA[0]));
                r_cmpf    <= w_set_cmp | (r_cmpf & ~(w_wr_st & apb.PWDATA[1]));
                r_irq_ovf <= r_ovf & r_oie;
                r_irq_cmp <= r_cmpf & r_cie;
            end
        end
    end
endmodule

// File: tb/tb_apb_timer_array.sv
// tb_apb_timer_array: directed scoreboard bench for apb_timer_array (TIMER_CNT=4, CNT_WIDTH=8)
module tb_apb_timer_array;
    localparam int TC = 4;
    localparam int CW = 8;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2*TC-1:0] irq;
    logic          last_err;
    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];

    apb_timer_array_if #(.APB_ADDR_WIDTH(12)) bus();
    apb_timer_array #(.APB_ADDR_WIDTH(12), .TIMER_CNT(TC), .CNT_WIDTH(CW)) dut (
        .HCLK(clk), .HRESETn(rst_n), .apb(bus), .irq_o(irq));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [11:0] ad(input int c, input int r);
        return 12'(c * 16 + r * 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = a; bus.PWDATA = d;
        @(posedge clk); #1;
        bus.PENABLE = 1;
        #1 last_err = bus.PSLVERR;
        @(posedge clk); #1;
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic e);
        @(posedge clk); #1;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = a;
        @(posedge clk); #1;
        bus.PENABLE = 1;
        #1 d = bus.PRDATA; e = bus.PSLVERR;
        @(posedge clk); #1;
        bus.PSEL = 0; bus.PENABLE = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] v);
        logic [31:0] d;
        logic        e;
        exp_q.push_back(v);
        rd(a, d, e);
        check(tag, d);
    endtask

    task automatic mon(input logic [11:0] a);
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = a;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        bit          seen;
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        exp_q.push_back(1); check("pready", 32'(bus.PREADY));
        exp_q.push_back(0); check("irq after reset", 32'(irq));
        for (int c = 0; c < TC; c++)
            for (int r = 0; r < 4; r++)
                rd_chk($sformatf("reset ch%0d reg%0d", c, r), ad(c, r), 0);
        rd(ad(0, 0), d, e);
        exp_q.push_back(0); check("pslverr legal", 32'(e));

        // ch0 periodic compare
        wr(ad(0, 2), 9);
        wr(ad(0, 0), 32'h9);
        mon(ad(0, 1));
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin @(posedge clk); #1; seen = (bus.PRDATA == 9); end
        exp_q.push_back(1); check("ch0 reaches 9", 32'(seen));
        for (int j = 0; j < 11; j++) begin
            @(posedge clk); #1;
            exp_q.push_back(32'(j % 10)); check("ch0 count seq", bus.PRDATA);
            if (j < 2) begin exp_q.push_back(32'(j)); check("ch0 irq1 latency", 32'(irq[1])); end
        end
        bus.PSEL = 0;
        wr(ad(0, 0), 32'h8);
        rd_chk("ch0 status cmp", ad(0, 3), 2);
        exp_q.push_back(1); check("ch0 irq1 held", 32'(irq[1]));
        wr(ad(0, 3), 0);
        rd_chk("ch0 w0 no effect", ad(0, 3), 2);
        wr(ad(0, 3), 2);
        @(posedge clk); #1;
        exp_q.push_back(0); check("ch0 irq1 cleared", 32'(irq[1]));
        rd_chk("ch0 status cleared", ad(0, 3), 0);

        // ch1 one-shot, prescaler 3
        wr(ad(1, 2), 4);
        wr(ad(1, 0), 32'h303);
        mon(ad(1, 1));
        #1;
        exp_q.push_back(0); check("ch1 count t0", bus.PRDATA);
        for (int i = 1; i <= 21; i++) begin
            @(posedge clk); #1;
            exp_q.push_back(i >= 20 ? 0 : 32'(i / 4)); check($sformatf("ch1 count t%0d", i), bus.PRDATA);
        end
        bus.PSEL = 0;
        rd_chk("ch1 ctrl en cleared", ad(1, 0), 32'h302);
        rd_chk("ch1 count stays 0", ad(1, 1), 0);
        rd_chk("ch1 status cmp", ad(1, 3), 2);
        wr(ad(1, 3), 2);
        repeat (40) @(posedge clk);
        rd_chk("ch1 single match", ad(1, 3), 0);
        exp_q.push_back(0); check("ch1 irq3 disabled", 32'(irq[3]));

        // ch2 overflow
        wr(ad(2, 2), 32'h10);
        wr(ad(2, 1), 32'hFE);
        wr(ad(2, 0), 32'h5);
        mon(ad(2, 1));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin #1; seen = (bus.PRDATA == 32'hFF); if (!seen) @(posedge clk); end
        exp_q.push_back(1); check("ch2 reaches ff", 32'(seen));
        @(posedge clk); #1;
        exp_q.push_back(0); check("ch2 wrap", bus.PRDATA);
        exp_q.push_back(0); check("ch2 irq4 latency", 32'(irq[4]));
        @(posedge clk); #1;
        exp_q.push_back(1); check("ch2 after wrap", bus.PRDATA);
        exp_q.push_back(1); check("ch2 irq4 set", 32'(irq[4]));
        bus.PSEL = 0;
        wr(ad(2, 0), 32'h4);
        rd_chk("ch2 status ovf", ad(2, 3), 1);
        wr(ad(2, 3), 1);
        rd_chk("ch2 status cleared", ad(2, 3), 0);
        wr(ad(2, 0), 32'h5);
        wr(ad(2, 1), 32'hFD);
        wr(ad(2, 3), 1);
        wr(ad(2, 0), 32'h4);
        rd_chk("ch2 set beats w1c", ad(2, 3), 1);
        exp_q.push_back(1); check("ch2 irq4 after race", 32'(irq[4]));

        // COUNT write coinciding with a tick
        wr(ad(3, 2), 32'hF0);
        wr(ad(3, 0), 32'h1);
        @(posedge clk); #1;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = ad(3, 1); bus.PWDATA = 32'h55;
        @(posedge clk); #1;
        bus.PENABLE = 1;
        @(posedge clk); #1;
        bus.PENABLE = 0; bus.PWRITE = 0;
        #1;
        exp_q.push_back(32'h55); check("ch3 write beats tick", bus.PRDATA);
        @(posedge clk); #1;
        exp_q.push_back(32'h56); check("ch3 next tick", bus.PRDATA);
        bus.PSEL = 0;
        wr(ad(3, 0), 0);
        rd_chk("ch3 no flag", ad(3, 3), 0);

        // out-of-range channel
        wr(ad(TC, 0), 32'hFFFF);
        exp_q.push_back(1); check("bad wr pslverr", 32'(last_err));
        rd(ad(TC, 1), d, e);
        exp_q.push_back(0); check("bad rd prdata", d);
        exp_q.push_back(1); check("bad rd pslverr", 32'(e));
        rd_chk("ch0 ctrl untouched", ad(0, 0), 32'h8);
        rd_chk("ch0 cmp untouched", ad(0, 2), 9);

`ifdef APB_TIMER_CASCADE_EN
        wr(ad(0, 0), 0);
        wr(ad(0, 1), 0);
        wr(ad(0, 2), 1);
        wr(ad(0, 3), 3);
        wr(ad(1, 1), 0);
        wr(ad(1, 2), 2);
        wr(ad(1, 3), 3);
        wr(ad(1, 0), 32'hFF11);
        rd_chk("ch1 cascade ctrl", ad(1, 0), 32'hFF11);
        wr(ad(0, 0), 32'h1);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin rd(ad(1, 3), d, e); seen = d[1]; end
        exp_q.push_back(1); check("cascade ch1 cmp", 32'(seen));
        wr(ad(0, 0), 32'h11);
        rd_chk("ch0 cascade bit ro", ad(0, 0), 32'h1);
        wr(ad(0, 0), 0);
        wr(ad(1, 0), 0);
`else
        wr(ad(1, 0), 32'h10);
        rd_chk("ctrl4 ignored", ad(1, 0), 0);
`endif

        // asynchronous reset mid-run
        wr(ad(0, 2), 3);
        wr(ad(0, 1), 0);
        wr(ad(0, 0), 32'h9);
        repeat (12) @(posedge clk);
        #1;
        exp_q.push_back(1); check("irq1 before reset", 32'(irq[1]));
        @(negedge clk);
        rst_n = 0;
        #1;
        exp_q.push_back(0); check("irq async drop", 32'(irq));
        @(posedge clk); #1;
        rst_n = 1;
        rd_chk("ch0 ctrl after reset", ad(0, 0), 0);
        rd_chk("ch0 count after reset", ad(0, 1), 0);
        rd_chk("ch0 status after reset", ad(0, 3), 0);
        rd_chk("ch2 status after reset", ad(2, 3), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
